// File: rtl/rv32i_types.sv
// Shared RV32I types: opcodes, ROB head entry, RVFI record and commit FSM states.
package rv32i_types;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned ORD_W = 64;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode       opcode;
    logic [REG_W-1:0]  rds;
    logic [XLEN-1:0]   ROB_val;
    logic              br_en;
    logic [XLEN-1:0]   br_target;
    logic              commit;
  } rob_t;

  typedef struct packed {
    logic              valid;
    logic [ORD_W-1:0]  order;
    logic [XLEN-1:0]   inst;
    logic [REG_W-1:0]  rs1_addr;
    logic [REG_W-1:0]  rs2_addr;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    logic [REG_W-1:0]  rd_addr;
    logic [XLEN-1:0]   rd_wdata;
    logic [XLEN-1:0]   pc_rdata;
    logic [XLEN-1:0]   pc_wdata;
    logic [XLEN-1:0]   mem_addr;
    logic [3:0]        mem_rmask;
    logic [3:0]        mem_wmask;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
  } rvfi_data;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } commit_state_t;

endpackage

// File: rtl/commit_unit.sv
// In-order retirement: architectural writes, RAT release, mispredict redirect/flush, RVFI.
module commit_unit
  import rv32i_types::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rob_ready,
  input  rob_t              rob_head,
  input  logic [TAG_W-1:0]  rob_tag,
  input  rvfi_data          rob_rvfi,
  output logic              regf_we,
  output logic [REG_W-1:0]  regf_rd,
  output logic [XLEN-1:0]   regf_data,
  output logic              rat_clr_en,
  output logic [REG_W-1:0]  rat_clr_rd,
  output logic [TAG_W-1:0]  rat_clr_tag,
  output logic              flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output rvfi_data          rvfi_out
);

  localparam int unsigned CNT_W = 3;

  commit_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ORD_W-1:0]  order_q, order_d;

  logic              commit_c;
  logic              mispredict_c;
  logic              write_c;
  logic              flush_d;
  logic              regf_we_d;
  logic [REG_W-1:0]  regf_rd_d;
  logic [XLEN-1:0]   regf_data_d;
  logic [TAG_W-1:0]  rat_tag_d;
  logic              redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_d;
  rvfi_data          rvfi_d;

  // The ROB already filtered on its own commit bit; it is intentionally not rechecked.
  logic unused_commit_c;
  assign unused_commit_c = rob_head.commit;

  // Next state, flush countdown and next-cycle output values.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    order_d          = order_q;
    commit_c         = 1'b0;
    mispredict_c     = 1'b0;
    write_c          = 1'b0;
    regf_we_d        = 1'b0;
    regf_rd_d        = '0;
    regf_data_d      = '0;
    rat_tag_d        = '0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    rvfi_d           = '0;

    case (state_q)
      RUN: begin
        commit_c     = rob_ready;
        mispredict_c = commit_c &&
                       (((rob_head.opcode == op_br) && rob_head.br_en) ||
                        (rob_head.opcode == op_jal) ||
                        (rob_head.opcode == op_jalr));
        if (mispredict_c) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    flush_d = (state_d == FLUSH);

    write_c = commit_c &&
              (rob_head.opcode != op_store) &&
              (rob_head.opcode != op_br) &&
              (rob_head.rds != '0);

    if (write_c) begin
      regf_we_d   = 1'b1;
      regf_rd_d   = rob_head.rds;
      regf_data_d = rob_head.ROB_val;
      rat_tag_d   = rob_tag;
    end

    if (mispredict_c) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = rob_head.br_target;
    end

    if (commit_c) begin
      rvfi_d       = rob_rvfi;
      rvfi_d.valid = 1'b1;
      rvfi_d.order = order_q;
      order_d      = order_q + ORD_W'(1);
    end
  end

  // FSM state, flush counter and retirement order counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      order_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      order_q <= order_d;
    end
  end

  // Registered outputs; everything not driven by a commit this cycle returns to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regf_we        <= 1'b0;
      regf_rd        <= '0;
      regf_data      <= '0;
      rat_clr_en     <= 1'b0;
      rat_clr_rd     <= '0;
      rat_clr_tag    <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      rvfi_out       <= '0;
    end else begin
      regf_we        <= regf_we_d;
      regf_rd        <= regf_rd_d;
      regf_data      <= regf_data_d;
      rat_clr_en     <= regf_we_d;
      rat_clr_rd     <= regf_rd_d;
      rat_clr_tag    <= rat_tag_d;
      flush          <= flush_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      rvfi_out       <= rvfi_d;
    end
  end

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: stimulus pushes expected next-cycle outputs, monitor compares.
module tb_commit_unit;
  import rv32i_types::*;

  localparam int unsigned FC = 3;

  typedef struct packed {
    logic              regf_we;
    logic [REG_W-1:0]  regf_rd;
    logic [XLEN-1:0]   regf_data;
    logic              rat_clr_en;
    logic [REG_W-1:0]  rat_clr_rd;
    logic [TAG_W-1:0]  rat_clr_tag;
    logic              flush;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    rvfi_data          rvfi;
  } obs_t;

  logic              clk;
  logic              rst;
  logic              rob_ready;
  rob_t              rob_head;
  logic [TAG_W-1:0]  rob_tag;
  rvfi_data          rob_rvfi;
  logic              regf_we;
  logic [REG_W-1:0]  regf_rd;
  logic [XLEN-1:0]   regf_data;
  logic              rat_clr_en;
  logic [REG_W-1:0]  rat_clr_rd;
  logic [TAG_W-1:0]  rat_clr_tag;
  logic              flush;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  rvfi_data          rvfi_out;

  commit_unit #(.FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .rst            (rst),
    .rob_ready      (rob_ready),
    .rob_head       (rob_head),
    .rob_tag        (rob_tag),
    .rob_rvfi       (rob_rvfi),
    .regf_we        (regf_we),
    .regf_rd        (regf_rd),
    .regf_data      (regf_data),
    .rat_clr_en     (rat_clr_en),
    .rat_clr_rd     (rat_clr_rd),
    .rat_clr_tag    (rat_clr_tag),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rvfi_out       (rvfi_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  // Bench-side reference state.
  logic [63:0] m_order = '0;
  int          m_flush_rem = 0;

  // Monitor: each negedge, compare DUT outputs with the oldest pending expectation.
  initial begin
    obs_t  e;
    obs_t  a;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a.regf_we        = regf_we;
        a.regf_rd        = regf_rd;
        a.regf_data      = regf_data;
        a.rat_clr_en     = rat_clr_en;
        a.rat_clr_rd     = rat_clr_rd;
        a.rat_clr_tag    = rat_clr_tag;
        a.flush          = flush;
        a.redirect_valid = redirect_valid;
        a.redirect_pc    = redirect_pc;
        a.rvfi           = rvfi_out;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", n, a, e);
        end
      end
    end
  end

  // Drive one cycle of inputs and push the hand-derived outputs for the following cycle.
  task automatic cycle(input logic r, input logic rdy, input rv32i_opcode op,
                       input logic [4:0] rds, input logic [31:0] val, input logic [3:0] tag,
                       input logic ben, input logic [31:0] tgt, input logic [31:0] inst,
                       input string nm);
    obs_t e;
    logic mp;
    logic wr;
    @(negedge clk);
    #1;
    rst                = r;
    rob_ready          = rdy;
    rob_head           = '0;
    rob_head.opcode    = op;
    rob_head.rds       = rds;
    rob_head.ROB_val   = val;
    rob_head.br_en     = ben;
    rob_head.br_target = tgt;
    rob_head.commit    = rdy;
    rob_tag            = tag;
    rob_rvfi           = '0;
    rob_rvfi.valid     = 1'b0;
    rob_rvfi.order     = 64'hFFFF_0000_FFFF_0000;
    rob_rvfi.inst      = inst;
    rob_rvfi.rd_addr   = rds;
    rob_rvfi.rd_wdata  = val;
    rob_rvfi.pc_rdata  = inst ^ 32'h6000_0000;
    rob_rvfi.mem_wmask = 4'hA;

    e = '0;
    if (!r) begin
      m_order     = '0;
      m_flush_rem = 0;
    end else if (m_flush_rem > 0) begin
      m_flush_rem = m_flush_rem - 1;
      e.flush     = (m_flush_rem > 0);
    end else if (rdy) begin
      mp = (op == op_br && ben) || op == op_jal || op == op_jalr;
      wr = (op != op_store) && (op != op_br) && (rds != 5'd0);
      if (wr) begin
        e.regf_we     = 1'b1;
        e.regf_rd     = rds;
        e.regf_data   = val;
        e.rat_clr_en  = 1'b1;
        e.rat_clr_rd  = rds;
        e.rat_clr_tag = tag;
      end
      if (mp) begin
        e.redirect_valid = 1'b1;
        e.redirect_pc    = tgt;
        e.flush          = 1'b1;
        m_flush_rem      = FC;
      end
      e.rvfi       = rob_rvfi;
      e.rvfi.valid = 1'b1;
      e.rvfi.order = m_order;
      m_order      = m_order + 64'd1;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm);
    cycle(1'b1, 1'b0, op_imm, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, nm);
  endtask

  task automatic alu(input logic [4:0] rds, input logic [31:0] val, input logic [3:0] tag,
                     input logic [31:0] inst, input string nm);
    cycle(1'b1, 1'b1, op_reg, rds, val, tag, 1'b0, 32'd0, inst, nm);
  endtask

  initial begin
    rst       = 1'b0;
    rob_ready = 1'b0;
    rob_head  = '0;
    rob_tag   = '0;
    rob_rvfi  = '0;

    // Reset with a commit presented: it must be discarded.
    cycle(1'b0, 1'b1, op_reg, 5'd9, 32'h1111_1111, 4'd2, 1'b0, 32'd0, 32'h100, "reset_discard");
    cycle(1'b0, 1'b0, op_reg, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, "reset_hold");

    // Basic ALU retirement, then the no-write cases.
    alu(5'd5, 32'hDEAD_BEEF, 4'd3, 32'h0000_0201, "alu_rd5");
    alu(5'd0, 32'h1234_5678, 4'd4, 32'h0000_0202, "alu_rd0");
    cycle(1'b1, 1'b1, op_store, 5'd7, 32'h0000_00AA, 4'd5, 1'b0, 32'd0, 32'h0000_0203, "store");
    cycle(1'b1, 1'b1, op_br, 5'd3, 32'h0, 4'd6, 1'b0, 32'h6000_0080, 32'h0000_0204, "br_not_taken");
    idle("idle0");

    // Taken branch: redirect + flush, commits during the flush are ignored.
    cycle(1'b1, 1'b1, op_br, 5'd0, 32'h0, 4'd7, 1'b1, 32'h6000_0040, 32'h0000_0301, "br_taken");
    alu(5'd6, 32'h0000_0066, 4'd8, 32'h0000_0302, "br_flush1_ign");
    alu(5'd6, 32'h0000_0067, 4'd9, 32'h0000_0303, "br_flush2_ign");
    alu(5'd6, 32'h0000_0068, 4'd10, 32'h0000_0304, "br_flush3_ign");
    idle("br_after");

    // jal with link write, three flush cycles, then commit resumes at N+4.
    cycle(1'b1, 1'b1, op_jal, 5'd1, 32'h6000_0008, 4'd11, 1'b0, 32'h6000_0100, 32'h0000_0401, "jal_link");
    alu(5'd2, 32'h2, 4'd12, 32'h0000_0402, "jal_n1_ign");
    alu(5'd2, 32'h3, 4'd13, 32'h0000_0403, "jal_n2_ign");
    alu(5'd2, 32'h4, 4'd14, 32'h0000_0404, "jal_n3_ign");
    alu(5'd2, 32'hCAFE_0004, 4'd15, 32'h0000_0405, "jal_resume");

    // jalr to x0: redirect without any register write.
    cycle(1'b1, 1'b1, op_jalr, 5'd0, 32'h6000_0020, 4'd1, 1'b0, 32'h6000_0200, 32'h0000_0501, "jalr_x0");
    idle("jalr_f1");
    idle("jalr_f2");
    idle("jalr_f3");

    // Back-to-back after a fresh reset: orders 0..3.
    cycle(1'b0, 1'b0, op_reg, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, "reset2");
    alu(5'd10, 32'hA000_0000, 4'd0, 32'h0000_0601, "b2b_0");
    alu(5'd11, 32'hA000_0001, 4'd1, 32'h0000_0602, "b2b_1");
    alu(5'd12, 32'hA000_0002, 4'd2, 32'h0000_0603, "b2b_2");
    alu(5'd13, 32'hA000_0003, 4'd3, 32'h0000_0604, "b2b_3");

    // Reset in the middle of a flush returns to RUN with order restarted.
    cycle(1'b1, 1'b1, op_jal, 5'd1, 32'h6000_0010, 4'd4, 1'b0, 32'h6000_0300, 32'h0000_0701, "jal_pre_rst");
    cycle(1'b0, 1'b1, op_reg, 5'd3, 32'h3, 4'd5, 1'b0, 32'd0, 32'h0000_0702, "rst_in_flush");
    alu(5'd14, 32'hBEEF_0000, 4'd6, 32'h0000_0703, "post_rst_commit");
    idle("final_idle");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
